// File: rtl/fpu_div_if.sv
// Request/response bundle for the iterative single-precision divider.
// Master drives operands and the request strobe; slave returns the quotient.
interface fpu_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;

  modport master (
    output i_data_a,
    output i_data_b,
    output i_valid,
    input  o_ready,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  i_data_a,
    input  i_data_b,
    input  i_valid,
    output o_ready,
    output o_data,
    output o_valid
  );
endinterface

// File: rtl/fpu_div.sv
// Iterative IEEE-754 single divider: restoring shift-subtract, 27-cycle latency.
// Denormals flush to zero; round to nearest even; one operation in flight.
module fpu_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  fpu_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [24:0]           rem_q, rem_d;
  logic [25:0]           q_q, q_d;
  logic [23:0]           mb_q, mb_d;
  logic [7:0]            ea_q, ea_d;
  logic [7:0]            eb_q, eb_d;
  logic                  sign_q, sign_d;
  logic                  za_q, za_d;
  logic                  zb_q, zb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic [24:0] diff;
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic [9:0]  e_n;
  logic [23:0] frac_inc;
  logic [9:0]  e_r;
  logic [31:0] res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      mb_q    <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      sign_q  <= 1'b0;
      za_q    <= 1'b0;
      zb_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      mb_q    <= mb_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      sign_q  <= sign_d;
      za_q    <= za_d;
      zb_q    <= zb_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Normalise the 26-bit quotient, then round to nearest even
  always_comb begin
    sticky = |rem_q;
    if (q_q[25]) begin
      frac   = q_q[24:2];
      guard  = q_q[1];
      sticky = sticky | q_q[0];
      e_n    = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127;
    end else begin
      frac   = q_q[23:1];
      guard  = q_q[0];
      e_n    = {2'b00, ea_q} - {2'b00, eb_q} + 10'd126;
    end
    frac_inc = {1'b0, frac}
             + {23'd0, guard & (sticky | frac[0])};
    e_r = e_n + {9'd0, frac_inc[23]};
    if (za_q) begin
      res = {sign_q, 31'd0};
    end else if (zb_q) begin
      res = {sign_q, 8'hFF, 23'd0};
    end else if ($signed(e_r) >= 10'sd255) begin
      res = {sign_q, 8'hFF, 23'd0};
    end else if ($signed(e_r) <= 10'sd0) begin
      res = {sign_q, 31'd0};
    end else begin
      res = {sign_q, e_r[7:0], frac_inc[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    mb_d    = mb_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    sign_d  = sign_q;
    za_d    = za_q;
    zb_d    = zb_q;
    data_d  = data_q;
    valid_d = 1'b0;
    diff    = rem_q - {1'b0, mb_q};
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          sign_d  = bus.i_data_a[31] ^ bus.i_data_b[31];
          ea_d    = bus.i_data_a[30:23];
          eb_d    = bus.i_data_b[30:23];
          za_d    = bus.i_data_a[30:23] == 8'd0;
          zb_d    = bus.i_data_b[30:23] == 8'd0;
          rem_d   = {2'b01, bus.i_data_a[22:0]};
          mb_d    = {1'b1, bus.i_data_b[22:0]};
          q_d     = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (rem_q >= {1'b0, mb_q}) begin
          q_d   = {q_q[24:0], 1'b1};
          rem_d = {diff[23:0], 1'b0};
        end else begin
          q_d   = {q_q[24:0], 1'b0};
          rem_d = {rem_q[23:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d  = res;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div: directed cases plus random operands
// compared against an integer-arithmetic model of the divide and rounding.
module tb_fpu_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  fpu_div_if #(.DATA_WIDTH(32)) bus ();

  fpu_div #(.DATA_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, num, q, r, mant;
    bit     g, st;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0) return {s, 31'd0};
    if (eb == 0) return {s, 8'hFF, 23'd0};
    ma  = 64'h800000 + longint'(a[22:0]);
    mb  = 64'h800000 + longint'(b[22:0]);
    num = ma * (64'd1 << 25);
    q   = num / mb;
    r   = num % mb;
    if (q >= (64'd1 << 25)) begin
      mant = q / 4;
      g    = ((q / 2) % 2) == 1;
      st   = ((q % 2) == 1) || (r != 0);
      e    = ea - eb + 127;
    end else begin
      mant = q / 2;
      g    = (q % 2) == 1;
      st   = (r != 0);
      e    = ea - eb + 126;
    end
    if (g && (st || (mant % 2) == 1)) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  // Issues one request from just after a rising edge; reports result,
  // latency in edges after acceptance (-1 on timeout) and o_ready behaviour.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output bit rdy_ok);
    bus.i_data_a = a;
    bus.i_data_b = b;
    bus.i_valid  = 1'b1;
    rdy_ok = (bus.o_ready === 1'b1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    if (bus.o_ready !== 1'b0) rdy_ok = 0;
    lat = -1;
    res = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        lat = n;
        res = bus.o_data;
        if (bus.o_ready !== 1'b1) rdy_ok = 0;
        break;
      end
      if (bus.o_ready !== 1'b0) rdy_ok = 0;
    end
  endtask

  task automatic test_reset;
    bus.i_valid  = 1'b0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b want=1", bus.o_ready);
    end
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got=%b want=0", bus.o_valid);
    end
    vectors++;
    if (bus.o_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got=%h want=00000000", bus.o_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [31:0] res;
    int lat;
    bit rok;
    do_req(32'h40C00000, 32'h40000000, res, lat, rok);
    vectors++;
    if (res !== 32'h40400000) begin
      miscompares++;
      $display("FAIL six_div_two got=%h want=40400000", res);
    end
    vectors++;
    if (lat != 27) begin
      miscompares++;
      $display("FAIL latency got=%0d want=27", lat);
    end
    vectors++;
    if (!rok) begin
      miscompares++;
      $display("FAIL ready_window got=bad want=low_k_to_k27");
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pulse_width got=v%b r%b want=v0 r1", bus.o_valid, bus.o_ready);
    end
    do_req(32'h3F800000, 32'h40400000, res, lat, rok);
    vectors++;
    if (res !== 32'h3EAAAAAB) begin
      miscompares++;
      $display("FAIL one_third got=%h want=3EAAAAAB", res);
    end
    do_req(32'hBF800000, 32'h40800000, res, lat, rok);
    vectors++;
    if (res !== 32'hBE800000) begin
      miscompares++;
      $display("FAIL neg_quarter got=%h want=BE800000", res);
    end
  endtask

  task automatic test_specials;
    logic [31:0] ta [5] = '{32'h3F800000, 32'h80000000, 32'h00000000,
                           32'h7F000000, 32'h00800000};
    logic [31:0] tb [5] = '{32'h00000000, 32'h3F800000, 32'h00000000,
                           32'h3E800000, 32'h40000000};
    logic [31:0] tw [5] = '{32'h7F800000, 32'h80000000, 32'h00000000,
                           32'h7F800000, 32'h00000000};
    logic [31:0] res;
    int lat;
    bit rok;
    for (int i = 0; i < 5; i++) begin
      do_req(ta[i], tb[i], res, lat, rok);
      vectors++;
      if (res !== tw[i] || lat != 27) begin
        miscompares++;
        $display("FAIL special_%0d got=%h lat=%0d want=%h lat=27", i, res, lat, tw[i]);
      end
    end
  endtask

  task automatic test_handshake;
    logic [31:0] a0, b0, a1, b1, a2, b2, d1, d2;
    int n1, n2, pulses;
    a0 = 32'h40C00000; b0 = 32'h40000000;
    a1 = 32'h3F800000; b1 = 32'h40400000;
    a2 = 32'hC1200000; b2 = 32'h40A00000;
    n1 = -1; n2 = -1; pulses = 0; d1 = '0; d2 = '0;
    bus.i_data_a = a0;
    bus.i_data_b = b0;
    bus.i_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin n1 = n; d1 = bus.o_data; end
        if (pulses == 2) begin n2 = n; d2 = bus.o_data; end
      end
      bus.i_valid = 1'b0;
      if (n == 4 || n == 26) begin
        bus.i_data_a = a1;
        bus.i_data_b = b1;
        bus.i_valid  = 1'b1;
      end
      if (n == 27) begin
        bus.i_data_a = a2;
        bus.i_data_b = b2;
        bus.i_valid  = 1'b1;
      end
    end
    vectors++;
    if (n1 != 27 || d1 !== ref_div(a0, b0)) begin
      miscompares++;
      $display("FAIL hs_first got=%h@%0d want=%h@27", d1, n1, ref_div(a0, b0));
    end
    vectors++;
    if (n2 != 55 || d2 !== ref_div(a2, b2)) begin
      miscompares++;
      $display("FAIL hs_second got=%h@%0d want=%h@55", d2, n2, ref_div(a2, b2));
    end
    vectors++;
    if (pulses != 2) begin
      miscompares++;
      $display("FAIL hs_pulses got=%0d want=2", pulses);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int lat, pulses;
    bit rok;
    do_req(32'h40C00000, 32'h40000000, res, lat, rok);
    bus.i_data_a = 32'h3F800000;
    bus.i_data_b = 32'h40400000;
    bus.i_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 32'h0 || bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset got=v%b d%h r%b want=v0 d00000000 r1",
               bus.o_valid, bus.o_data, bus.o_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL aborted_valid got=%0d want=0", pulses);
    end
    do_req(32'h40C00000, 32'h40000000, res, lat, rok);
    vectors++;
    if (res !== 32'h40400000 || lat != 27) begin
      miscompares++;
      $display("FAIL post_reset got=%h@%0d want=40400000@27", res, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, res, want;
    int lat;
    bit rok;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 != 0) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      if (i % 17 == 3) b[30:23] = 8'd0;
      if (i % 19 == 5) a[30:23] = 8'd0;
      want = ref_div(a, b);
      do_req(a, b, res, lat, rok);
      vectors++;
      if (res !== want || lat != 27 || !rok) begin
        miscompares++;
        $display("FAIL random_%0d a=%h b=%h got=%h lat=%0d rdy=%0b want=%h lat=27",
                 i, a, b, res, lat, rok, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
